// File: rtl/seq_mult_bcd.sv
// seq_mult_bcd: sequential shift-add multiplier that retires K multiplier bits
// per clock. It handles unsigned or two's-complement operands and uses a
// start/busy/done handshake. Define MULT_BCD_EN to add a double-dabble stage
// that converts |product| to packed BCD on bcd_out. When the macro is left
// undefined, bcd_out is tied to zero.
module seq_mult_bcd #(
    parameter int N = 8,
    parameter int K = 1,
    localparam int D = ((2*N)/3)+1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           signed_mode,
    input  logic [N-1:0]   a_in,
    input  logic [N-1:0]   b_in,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product,
    output logic           neg,
    output logic [4*D-1:0] bcd_out
);
    localparam int W  = 2*N;
    localparam int CW = $clog2(W+1);

`ifdef MULT_BCD_EN
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_BCD, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;
`endif

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, a_d;       // multiplicand magnitude, shifts left
    logic [N-1:0]   b_q, b_d;       // multiplier magnitude, shifts right
    logic [W-1:0]   acc_q, acc_d;   // partial product, then the BCD source
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           s_q, s_d;       // result sign
    logic [W-1:0]   product_q, product_d;
    logic           neg_q, neg_d;
    logic [W-1:0]   step_sum;
    logic [N-1:0]   a_mag, b_mag;
`ifdef MULT_BCD_EN
    logic [4*D-1:0] work_q, work_d; // double-dabble digit register
    logic [4*D-1:0] adj;
    logic [4*D-1:0] bcd_q, bcd_d;
`endif

    // Next-state and datapath: operand capture, shift-add and double dabble
    always_comb begin
        // NOTE: every output of this block gets a default first, so that no path leaves one unassigned and infers a latch.
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        s_d       = s_q;
        product_d = product_q;
        neg_d     = neg_q;
`ifdef MULT_BCD_EN
        work_d    = work_q;
        bcd_d     = bcd_q;
        adj       = '0;
`endif
        // NOTE: blocking assignments here, because step_sum builds up across
        // the loop within one evaluation.
        step_sum = acc_q;
        for (int j = 0; j < K; j++) begin
            if (b_q[j]) step_sum = step_sum + (a_q << j);
        end
        a_mag = (signed_mode && a_in[N-1]) ? (~a_in + N'(1)) : a_in;
        b_mag = (signed_mode && b_in[N-1]) ? (~b_in + N'(1)) : b_in;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = W'(a_mag);
                    b_d     = b_mag;
                    s_d     = signed_mode & (a_in[N-1] ^ b_in[N-1]);
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                acc_d = step_sum;
                a_d   = a_q << K;
                b_d   = b_q >> K;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N/K - 1)) begin
                    product_d = s_q ? (~step_sum + W'(1)) : step_sum;
                    neg_d     = s_q & (step_sum != '0);
                    cnt_d     = '0;
`ifdef MULT_BCD_EN
                    work_d    = '0;
                    state_d   = S_BCD;
`else
                    state_d   = S_DONE;
`endif
                end
            end
`ifdef MULT_BCD_EN
            S_BCD: begin
                for (int i = 0; i < D; i++) begin
                    adj[4*i +: 4] = (work_q[4*i +: 4] >= 4'd5) ? work_q[4*i +: 4] + 4'd3
                                                               : work_q[4*i +: 4];
                end
                {work_d, acc_d} = {adj[4*D-2:0], acc_q, 1'b0};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    bcd_d   = work_d;
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            s_q       <= 1'b0;
            product_q <= '0;
            neg_q     <= 1'b0;
`ifdef MULT_BCD_EN
            work_q    <= '0;
            bcd_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            s_q       <= s_d;
            product_q <= product_d;
            neg_q     <= neg_d;
`ifdef MULT_BCD_EN
            work_q    <= work_d;
            bcd_q     <= bcd_d;
`endif
        end
    end

`ifdef MULT_BCD_EN
    assign busy    = (state_q == S_MUL) || (state_q == S_BCD);
    assign bcd_out = bcd_q;
`else
    assign busy    = (state_q == S_MUL);
    assign bcd_out = '0;
`endif
    assign done    = (state_q == S_DONE);
    assign product = product_q;
    assign neg     = neg_q;

endmodule
